// File: rtl/seg7_scan_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seg7_scan_if                                                    |
// | Purpose  : Bundle between value producers and the seven-segment scanner.   |
// |            The producer (master) drives six BCD nibbles, the decimal-point |
// |            mask and the display controls. The scanner (slave) drives the   |
// |            board pins and the frame_start pulse.                           |
// | Signals  : digits[23:0]  BCD nibbles, [3:0] = digit0 (rightmost, sel 5)    |
// |            dp_mask[5:0]  bit i lights the decimal point of digit i         |
// |            lz_en         leading-zero suppression enable                   |
// |            blank_all     force all segments and dp off                     |
// |            seg7_sel[2:0] active digit select, digit i -> sel 5-i           |
// |            seg7_out[6:0] segments abcdefg, bit6 = a, active-high           |
// |            dpt_out       decimal point, active-high                        |
// |            frame_start   one-cycle pulse when a frame snapshot is taken    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface seg7_scan_if;
  logic [23:0] digits;
  logic [5:0]  dp_mask;
  logic        lz_en;
  logic        blank_all;
  logic [2:0]  seg7_sel;
  logic [6:0]  seg7_out;
  logic        dpt_out;
  logic        frame_start;

  modport master (
    output digits, dp_mask, lz_en, blank_all,
    input  seg7_sel, seg7_out, dpt_out, frame_start
  );

  modport slave (
    input  digits, dp_mask, lz_en, blank_all,
    output seg7_sel, seg7_out, dpt_out, frame_start
  );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seg7_scan_ctrl                                                  |
// | Purpose  : Time-multiplexed scan scheduler for a 6-digit seven-segment     |
// |            display. Each digit dwells 2^DIV_EXP cycles; the first          |
// |            BLANK_CYC cycles of every dwell are blanked to avoid ghosting.  |
// |            Inputs are snapshotted once per frame (entering SHOW at sel 5)  |
// |            so a frame never mixes old and new values.                      |
// | Ports    : clk            system clock                                     |
// |            reset          synchronous, active-high                         |
// |            bus (slave)    digits/dp_mask/lz_en/blank_all in,               |
// |                           seg7_sel/seg7_out/dpt_out/frame_start out        |
// | Params   : DIV_EXP   (2..24) dwell = 2^DIV_EXP cycles                      |
// |            NUM_USE   (1..6)  digits scanned, rightmost first               |
// |            BLANK_CYC (1 .. 2^DIV_EXP-1) blank cycles per dwell             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module seg7_scan_ctrl #(
  parameter int DIV_EXP   = 17,
  parameter int NUM_USE   = 6,
  parameter int BLANK_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  seg7_scan_if.slave bus
);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  localparam logic [2:0]         C_SEL_FIRST  = 3'd5;
  localparam logic [2:0]         C_SEL_LAST   = 3'(6 - NUM_USE);
  localparam logic [DIV_EXP-1:0] C_BLANK_LAST = DIV_EXP'(BLANK_CYC - 1);

  state_e               state_q,       state_d;
  logic [DIV_EXP-1:0]   div_cnt_q,     div_cnt_d;
  logic [DIV_EXP-1:0]   blank_cnt_q,   blank_cnt_d;
  logic [2:0]           sel_q,         sel_d;
  logic [23:0]          snap_digits_q, snap_digits_d;
  logic [5:0]           snap_dp_q,     snap_dp_d;
  logic                 frame_start_q, frame_start_d;

  logic                 tick;
  logic [2:0]           digit_idx;
  logic [3:0]           nibble;
  logic                 upper_zero;
  logic                 suppress;
  logic [6:0]           seg_out;
  logic                 dpt;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Dwell divider wraps freely; its terminal count marks the end of a dwell.
  assign tick = &div_cnt_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_BLANK;
      div_cnt_q     <= '0;
      blank_cnt_q   <= '0;
      sel_q         <= C_SEL_FIRST;
      snap_digits_q <= '0;
      snap_dp_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      blank_cnt_q   <= blank_cnt_d;
      sel_q         <= sel_d;
      snap_digits_q <= snap_digits_d;
      snap_dp_q     <= snap_dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    div_cnt_d     = div_cnt_q + DIV_EXP'(1);
    blank_cnt_d   = blank_cnt_q;
    sel_d         = sel_q;
    snap_digits_d = snap_digits_q;
    snap_dp_d     = snap_dp_q;
    frame_start_d = 1'b0;

    case (state_q)
      ST_SHOW: begin
        if (tick) begin
          sel_d       = (sel_q == C_SEL_LAST) ? C_SEL_FIRST : sel_q - 3'd1;
          blank_cnt_d = '0;
          state_d     = ST_BLANK;
        end
      end
      default: begin
        // BLANK_CYC < dwell length, so a tick can never land here.
        if (blank_cnt_q != C_BLANK_LAST) begin
          blank_cnt_d = blank_cnt_q + DIV_EXP'(1);
        end else begin
          state_d = ST_SHOW;
          // Entering SHOW on the first digit starts a new frame: take the
          // snapshot here so the whole frame shows one consistent value.
          if (sel_q == C_SEL_FIRST) begin
            snap_digits_d = bus.digits;
            snap_dp_d     = bus.dp_mask;
            frame_start_d = 1'b1;
          end
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode (combinational from registers, lz_en/blank_all live)
  // ---------------------------------------------------------------------------
  always_comb begin
    digit_idx  = C_SEL_FIRST - sel_q;
    nibble     = snap_digits_q[{digit_idx, 2'b00} +: 4];

    // A digit is a leading zero when it and every used digit to its left
    // are zero.
    upper_zero = 1'b1;
    for (int k = 0; k < NUM_USE; k++) begin
      if ((3'(k) >= digit_idx) && (snap_digits_q[4*k +: 4] != 4'd0)) begin
        upper_zero = 1'b0;
      end
    end
    suppress   = bus.lz_en && (digit_idx != 3'd0) && upper_zero;

    seg_out    = 7'b0000000;
    dpt        = 1'b0;
    if ((state_q == ST_SHOW) && !bus.blank_all) begin
      seg_out = suppress ? 7'b0000000 : seg_decode(nibble);
      dpt     = snap_dp_q[digit_idx];
    end
  end

  assign bus.seg7_sel    = sel_q;
  assign bus.seg7_out    = seg_out;
  assign bus.dpt_out     = dpt;
  assign bus.frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_seg7_scan_ctrl                                               |
// | Purpose  : Self-checking bench for seg7_scan_ctrl. Two instances run side  |
// |            by side (NUM_USE=6 and NUM_USE=3, DIV_EXP=4, BLANK_CYC=2).      |
// |            Every cycle is compared against a cycle-count based reference   |
// |            model; a vector table and hand-written sequences add fixed      |
// |            expected values for the main corner cases.                      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_seg7_scan_ctrl;

  localparam int DWELL = 16;
  localparam int BL    = 2;

  logic clk = 1'b0;
  logic reset;

  seg7_scan_if bus ();
  seg7_scan_if bus3 ();

  seg7_scan_ctrl #(.DIV_EXP(4), .NUM_USE(6), .BLANK_CYC(BL)) u_dut6 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  seg7_scan_ctrl #(.DIV_EXP(4), .NUM_USE(3), .BLANK_CYC(BL)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  assign bus3.digits    = bus.digits;
  assign bus3.dp_mask   = bus.dp_mask;
  assign bus3.lz_en     = bus.lz_en;
  assign bus3.blank_all = bus.blank_all;

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: cycles since reset release plus per-instance snapshot.
  int          mc;
  logic [23:0] ms6, ms3;
  logic [5:0]  md6, md3;

  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'd0: return 7'b1111110;
      4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;
      4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;
      4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;
      4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  // Output expected c cycles after reset release for a scan of nu digits.
  function automatic void model(input int c, input int nu, input logic [23:0] s,
                                input logic [5:0] sd, input logic lz, input logic ba,
                                output logic [2:0] esel, output logic [6:0] eseg,
                                output logic edp, output logic efs);
    int d, p, i;
    logic sup;
    d    = c / DWELL;
    p    = c % DWELL;
    i    = d % nu;
    esel = 3'(5 - i);
    efs  = (p == BL) && (i == 0);
    eseg = 7'd0;
    edp  = 1'b0;
    if (p >= BL && !ba) begin
      sup = lz && (i >= 1);
      for (int k = i; k < nu; k++) if (s[4*k +: 4] != 4'd0) sup = 1'b0;
      eseg = sup ? 7'd0 : dec(s[4*i +: 4]);
      edp  = sd[i];
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t cycle=%0d)", name, act, exp, $time, mc);
  endtask

  // One clock edge: advance the model, then compare both instances.
  task automatic tick1();
    logic [2:0] es; logic [6:0] eg; logic ed, ef;
    @(posedge clk);
    if (reset) begin
      mc = 0; ms6 = '0; md6 = '0; ms3 = '0; md3 = '0;
    end else begin
      mc++;
      if (mc % DWELL == BL && (mc / DWELL) % 6 == 0) begin ms6 = bus.digits; md6 = bus.dp_mask; end
      if (mc % DWELL == BL && (mc / DWELL) % 3 == 0) begin ms3 = bus.digits; md3 = bus.dp_mask; end
    end
    #1;
    model(mc, 6, ms6, md6, bus.lz_en, bus.blank_all, es, eg, ed, ef);
    chk("sel6", 32'(bus.seg7_sel), 32'(es));
    chk("seg6", 32'(bus.seg7_out), 32'(eg));
    chk("dp6",  32'(bus.dpt_out), 32'(ed));
    chk("fs6",  32'(bus.frame_start), 32'(ef));
    model(mc, 3, ms3, md3, bus.lz_en, bus.blank_all, es, eg, ed, ef);
    chk("sel3", 32'(bus3.seg7_sel), 32'(es));
    chk("seg3", 32'(bus3.seg7_out), 32'(eg));
    chk("dp3",  32'(bus3.dpt_out), 32'(ed));
    chk("fs3",  32'(bus3.frame_start), 32'(ef));
  endtask

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (mc < target && guard < 4000) begin
      tick1();
      guard++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick1();
    chk("rst_sel", 32'(bus.seg7_sel), 32'd5);
    chk("rst_seg", 32'(bus.seg7_out), 32'd0);
    chk("rst_dp",  32'(bus.dpt_out), 32'd0);
    chk("rst_fs",  32'(bus.frame_start), 32'd0);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [23:0] digits;
    logic [5:0]  dp;
    logic        lz;
    logic        ba;
    logic [41:0] seg;   // {digit5 .. digit0}, 7 bits each
    logic [5:0]  dpx;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{24'h000123, 6'b000000, 1'b0, 1'b0,
                {7'b1111110, 7'b1111110, 7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001}, 6'b000000};
    vecs[1] = '{24'h000123, 6'b000000, 1'b1, 1'b0,
                {7'b0000000, 7'b0000000, 7'b0000000, 7'b0110000, 7'b1101101, 7'b1111001}, 6'b000000};
    vecs[2] = '{24'h000000, 6'b000000, 1'b1, 1'b0,
                {7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}, 6'b000000};
    vecs[3] = '{24'h000A00, 6'b000100, 1'b0, 1'b0,
                {7'b1111110, 7'b1111110, 7'b1111110, 7'b0000000, 7'b1111110, 7'b1111110}, 6'b000100};
    vecs[4] = '{24'h987654, 6'b111111, 1'b0, 1'b1,
                {7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000}, 6'b000000};
    vecs[5] = '{24'h987654, 6'b101010, 1'b1, 1'b0,
                {7'b1111011, 7'b1111111, 7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011}, 6'b101010};

    mc = 0; ms6 = '0; md6 = '0; ms3 = '0; md3 = '0;
    reset         = 1'b1;
    bus.digits    = 24'h000123;
    bus.dp_mask   = 6'b0;
    bus.lz_en     = 1'b0;
    bus.blank_all = 1'b0;
    repeat (3) tick1();

    // ---- Table: one full frame per vector, fixed expected per digit ----
    for (int v = 0; v < 6; v++) begin
      bus.digits    = vecs[v].digits;
      bus.dp_mask   = vecs[v].dp;
      bus.lz_en     = vecs[v].lz;
      bus.blank_all = vecs[v].ba;
      do_reset();
      tick1();
      chk("first_blank", 32'(bus.seg7_out), 32'd0);
      for (int d = 0; d < 6; d++) begin
        run_to(d * DWELL + BL);
        chk("tab_sel", 32'(bus.seg7_sel), 32'(5 - d));
        chk("tab_seg", 32'(bus.seg7_out), 32'(vecs[v].seg[7*d +: 7]));
        chk("tab_dp",  32'(bus.dpt_out), 32'(vecs[v].dpx[d]));
        if (d == 0) chk("tab_fs", 32'(bus.frame_start), 32'd1);
      end
    end

    // ---- Snapshot: change digits mid-frame ----
    bus.digits = 24'h000123; bus.dp_mask = '0; bus.lz_en = 1'b0; bus.blank_all = 1'b0;
    do_reset();
    run_to(DWELL + 4);
    bus.digits = 24'h000456;
    run_to(2 * DWELL + 4);  chk("snap_old_d2", 32'(bus.seg7_out), 32'(7'b0110000));
    run_to(3 * DWELL + 4);  chk("snap_old_d3", 32'(bus.seg7_out), 32'(7'b1111110));
    run_to(6 * DWELL + 4);  chk("snap_new_d0", 32'(bus.seg7_out), 32'(7'b1011111));
    run_to(7 * DWELL + 4);  chk("snap_new_d1", 32'(bus.seg7_out), 32'(7'b1011011));
    run_to(8 * DWELL + 4);  chk("snap_new_d2", 32'(bus.seg7_out), 32'(7'b0110011));

    // ---- NUM_USE=3: sel wraps 3 -> 5 with a frame_start ----
    run_to(9 * DWELL + BL);
    chk("nu3_wrap_sel", 32'(bus3.seg7_sel), 32'd5);
    chk("nu3_wrap_fs",  32'(bus3.frame_start), 32'd1);

    // ---- Reset during SHOW at sel=2 ----
    bus.digits = 24'h000123;
    do_reset();
    run_to(3 * DWELL + 5);
    chk("pre_rst_sel", 32'(bus.seg7_sel), 32'd2);
    do_reset();
    tick1();
    chk("post_rst_c1_seg", 32'(bus.seg7_out), 32'd0);
    tick1();
    chk("post_rst_c2_seg", 32'(bus.seg7_out), 32'(7'b1111001));
    chk("post_rst_c2_fs",  32'(bus.frame_start), 32'd1);

    // ---- Randomised run against the model ----
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        logic [23:0] r;
        for (int k = 0; k < 6; k++)
          r[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        bus.digits  = r;
        bus.dp_mask = 6'($urandom);
      end
      if ($urandom_range(0, 29) == 0) bus.lz_en = ~bus.lz_en;
      if ($urandom_range(0, 39) == 0) bus.blank_all = ~bus.blank_all;
      reset = ($urandom_range(0, 299) == 0);
      tick1();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexing scan scheduler for the shared 6-digit seven-segment display. It owns the display, and value producers (counters, timers) drive six BCD nibbles plus a decimal-point mask. The block sequences the digit select, inserts a blanking gap between digits to prevent ghosting, and latches inputs once per frame so frames are tear-free. It also applies optional leading-zero suppression and global blanking, and feeds the board seg7_sel/seg7_out/dpt_out pins directly.

Parameters:
DIV_EXP, 17, digit dwell period is 2^DIV_EXP clk cycles; legal range 2..24.
NUM_USE, 6, number of digits scanned (1..6); rightmost digits are used first.
BLANK_CYC, 4, blanking cycles after each digit change; requires 1 <= BLANK_CYC < 2^DIV_EXP.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
digits  in  24  six BCD nibbles; [3:0] = digit0 (rightmost, sel 5), [23:20] = digit5 (sel 0)
dp_mask  in  6  bit i lights the decimal point of digit i
lz_en  in  1  leading-zero suppression enable
blank_all  in  1  forces all segments and dp off; scanning continues
seg7_sel  out  3  active digit select; digit i maps to sel = 5-i
seg7_out  out  7  segments abcdefg, bit6 = a, active-high
dpt_out  out  1  decimal point, active-high
frame_start  out  1  one-cycle pulse when a new frame snapshot is taken

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Registers: div_cnt[DIV_EXP-1:0], state {BLANK, SHOW}, blank_cnt, sel, snap_digits[23:0], snap_dp[5:0], frame_start.
- Reset (also mid-operation, takes priority): div_cnt=0, state=BLANK, blank_cnt=0, sel=5, snap_digits=0, snap_dp=0, frame_start=0. Outputs: seg7_out=0, dpt_out=0, seg7_sel=5.
- div_cnt is free-running and wraps. tick = (div_cnt == all ones).
- SHOW, on tick:
  - sel advances: sel-1, or wraps to 5 when sel == 6-NUM_USE.
  - blank_cnt=0; state goes to BLANK.
- SHOW, no tick: hold.
- BLANK, while blank_cnt != BLANK_CYC-1: blank_cnt+1.
- BLANK, when blank_cnt == BLANK_CYC-1: go to SHOW.
  - If sel == 5, on that same edge: snap_digits<=digits, snap_dp<=dp_mask, and frame_start=1 for exactly that one SHOW cycle.
- A tick during BLANK is ignored. It cannot occur given the BLANK_CYC constraint.
- Digit order per frame: 5,4,...,6-NUM_USE, then back to 5. With NUM_USE=1, sel stays 5 and every dwell is a new frame.
- Outputs are combinational from registers, so there is zero latency.
  - BLANK, or blank_all=1: seg7_out=0, dpt_out=0.
  - SHOW: i = 5-sel, n = snap nibble i.
    - seg7_out = decode(n), where 0..9 map to 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011.
    - n > 9 gives 0000000.
    - dpt_out = snap_dp[i].
- Leading-zero suppression: when lz_en=1, i >= 1, and snap nibbles i..NUM_USE-1 are all 0, seg7_out=0. Digit0 is never suppressed. dpt_out is not affected by suppression.
- lz_en and blank_all are not snapshotted; they take effect immediately.
- First frame after reset is shown BLANK_CYC cycles after reset release, at sel=5, with a frame_start pulse.

Test Plan:
Use DIV_EXP=4, BLANK_CYC=2, NUM_USE=6 unless stated otherwise.
1. digits=24'h000123, lz_en=0 -> sel=5 blank for 2 cycles, then frame_start=1 and seg7_out=1111001. Each 16-cycle dwell then gives sel 4,3,2,1,0 with 1101101, 0110000, 1111110, 1111110, 1111110. Each dwell starts with 2 blank cycles of outputs 0. Next sel=5 repeats with a frame_start pulse.
2. lz_en=1 with 24'h000123 -> sel 2,1,0 show 0000000 while sel 5,4,3 show 3,2,1. With digits=0 -> only sel=5 shows 1111110.
3. digits changed from 24'h000123 to 24'h000456 while sel=4 -> that frame still shows 2,1,0,0,0. The next frame shows 6 (1011111), 5 (1011011), 4 (0110011).
4. NUM_USE=3 -> sel sequence is 5,4,3,5,... and frame_start pulses once every 3 dwells (48 cycles).
5. dp_mask=6'b000100, digit2=4'hA -> at sel=3 seg7_out=0 and dpt_out=1; dpt_out=0 during blanking. blank_all=1 -> outputs 0 while sel keeps cycling.
6. reset asserted for 1 cycle during SHOW at sel=2 -> next cycle sel=5, outputs 0, frame_start=0. First display occurs 2 cycles after release.
